// File: rtl/legv8_pkg.sv
// Shared definitions for the multi-cycle LEGv8 control path: FSM states, opcode
// constants and the encodings driven onto the datapath select lines.
package legv8_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_LD  = 4'd6,
        S_MEM_WR = 4'd7,
        S_CBZ    = 4'd8,
        S_BR     = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILL  = 3'd0,
        CLS_R    = 3'd1,
        CLS_LDUR = 3'd2,
        CLS_STUR = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_B    = 3'd5
    } opc_class_t;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ8 = 8'b10110100;
    localparam logic [5:0]  OPC_B6   = 6'b000101;

    localparam logic [1:0] IMM_D  = 2'b00;
    localparam logic [1:0] IMM_CB = 2'b01;
    localparam logic [1:0] IMM_B  = 2'b10;

    localparam logic [1:0] ALUSRC_A_PC    = 2'b00;
    localparam logic [1:0] ALUSRC_A_OLDPC = 2'b01;
    localparam logic [1:0] ALUSRC_A_RN    = 2'b10;
    localparam logic [1:0] ALUSRC_B_REG   = 2'b00;
    localparam logic [1:0] ALUSRC_B_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRC_B_IMM   = 2'b10;
    localparam logic [1:0] ALUSRC_B_IMM4  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_BUS     = 2'b10;

endpackage

// File: rtl/legv8_opc_decode.sv
// Opcode classifier: maps instr[31:21] to an instruction class and the
// sign-extend format that class needs.
module legv8_opc_decode
    import legv8_pkg::*;
(
    input  logic [10:0] i_opc,
    output opc_class_t  o_class,
    output logic [1:0]  o_imm_sel
);

    // Short fixed fields (B, CBZ) are matched before the full 11-bit opcodes.
    always_comb begin
        o_class   = CLS_ILL;
        o_imm_sel = IMM_D;
        if (i_opc[10:5] == OPC_B6) begin
            o_class   = CLS_B;
            o_imm_sel = IMM_B;
        end else if (i_opc[10:3] == OPC_CBZ8) begin
            o_class   = CLS_CBZ;
            o_imm_sel = IMM_CB;
        end else begin
            case (i_opc)
                OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: o_class = CLS_R;
                OPC_LDUR: o_class = CLS_LDUR;
                OPC_STUR: o_class = CLS_STUR;
                default:  o_class = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM of the multi-cycle LEGv8 core: sequences fetch, decode,
// execute, memory and writeback, with memory-timeout and illegal-opcode traps.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_alu_zero,
    input  logic        i_mem_ready,
    output logic        o_pc_we,
    output logic        o_pc_src,
    output logic        o_ir_we,
    output logic [1:0]  o_imm_sel,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_iord,
    output logic        o_reg_we,
    output logic        o_mem_to_reg,
    output logic        o_retire,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_retire;
    logic             r_trap;
    logic [1:0]       r_trap_cause;

    opc_class_t w_class;
    logic [1:0] w_dec_imm_sel;
    logic       w_pc_we, w_pc_src, w_ir_we, w_mem_req, w_mem_we, w_iord;
    logic       w_reg_we, w_mem_to_reg, w_retire_next;
    logic [1:0] w_imm_sel, w_alu_src_a, w_alu_src_b, w_alu_op;
    logic       w_mem_wait, w_tmo_hit, w_trap_set;
    logic [1:0] w_trap_cause_set;
    logic       w_unused_instr;

    assign w_unused_instr = ^i_instr[20:0];

    legv8_opc_decode u_opc_decode (
        .i_opc     (i_instr[31:21]),
        .o_class   (w_class),
        .o_imm_sel (w_dec_imm_sel)
    );

    // Datapath controls decoded from the current state, opcode and handshakes.
    always_comb begin
        w_pc_we = 1'b0;  w_pc_src = 1'b0;  w_ir_we = 1'b0;  w_mem_req = 1'b0;
        w_mem_we = 1'b0; w_iord = 1'b0;    w_reg_we = 1'b0; w_mem_to_reg = 1'b0;
        w_imm_sel = IMM_D;          w_alu_src_a = ALUSRC_A_PC;
        w_alu_src_b = ALUSRC_B_REG; w_alu_op = ALUOP_ADD;
        w_retire_next = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = ALUSRC_B_FOUR;
                w_ir_we     = i_mem_ready;
                w_pc_we     = i_mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = ALUSRC_A_OLDPC;
                w_alu_src_b = ALUSRC_B_IMM4;
                w_imm_sel   = w_dec_imm_sel;
                if (w_class == CLS_CBZ || w_class == CLS_B) begin
                    w_retire_next = 1'b1;
                end else begin
                    w_retire_next = 1'b0;
                end
            end
            S_EXEC_R: begin
                w_alu_src_a   = ALUSRC_A_RN;
                w_alu_op      = ALUOP_FUNCT;
                w_retire_next = 1'b1;
            end
            S_WB_R: w_reg_we = 1'b1;
            S_ADDR: begin
                w_alu_src_a = ALUSRC_A_RN;
                w_alu_src_b = ALUSRC_B_IMM;
            end
            S_MEM_RD: begin
                w_mem_req     = 1'b1;
                w_iord        = 1'b1;
                w_retire_next = i_mem_ready;
            end
            S_WB_LD: begin
                w_reg_we     = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            // A store completes on its last memory cycle, so its registered
            // retire pulse lands in the following fetch cycle.
            S_MEM_WR: begin
                w_mem_req     = 1'b1;
                w_mem_we      = 1'b1;
                w_iord        = 1'b1;
                w_retire_next = i_mem_ready;
            end
            S_CBZ: begin
                w_alu_src_a = ALUSRC_A_RN;
                w_alu_op    = ALUOP_PASSB;
                w_pc_we     = i_alu_zero;
                w_pc_src    = 1'b1;
            end
            S_BR: begin
                w_pc_we  = 1'b1;
                w_pc_src = 1'b1;
            end
            default: w_pc_we = 1'b0;
        endcase
    end

    assign w_mem_wait       = w_mem_req & ~i_mem_ready;
    assign w_tmo_hit        = w_mem_wait && (r_tmo_cnt == TMO_LAST);
    assign w_trap_set       = w_tmo_hit || ((r_state == S_DECODE) && (w_class == CLS_ILL));
    assign w_trap_cause_set = w_tmo_hit ? TRAP_BUS : TRAP_ILLEGAL;

    // Gating with rst_n drops requests and enables the moment reset asserts.
    assign o_pc_we      = rst_n & w_pc_we;
    assign o_pc_src     = rst_n & w_pc_src;
    assign o_ir_we      = rst_n & w_ir_we;
    assign o_mem_req    = rst_n & w_mem_req;
    assign o_mem_we     = rst_n & w_mem_we;
    assign o_iord       = rst_n & w_iord;
    assign o_reg_we     = rst_n & w_reg_we;
    assign o_mem_to_reg = rst_n & w_mem_to_reg;
    assign o_imm_sel    = rst_n ? w_imm_sel   : 2'b00;
    assign o_alu_src_a  = rst_n ? w_alu_src_a : 2'b00;
    assign o_alu_src_b  = rst_n ? w_alu_src_b : 2'b00;
    assign o_alu_op     = rst_n ? w_alu_op    : 2'b00;
    assign o_retire     = r_retire;
    assign o_trap       = r_trap;
    assign o_trap_cause = r_trap_cause;

    // State sequencing, memory timeout counter and sticky trap record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_tmo_cnt    <= '0;
            r_retire     <= 1'b0;
            r_trap       <= 1'b0;
            r_trap_cause <= TRAP_NONE;
        end else begin
            r_retire  <= w_retire_next;
            r_tmo_cnt <= w_mem_wait ? r_tmo_cnt + TMO_W'(1) : '0;
            if (w_trap_set && !r_trap) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_trap_cause_set;
            end else begin
                r_trap       <= r_trap;
                r_trap_cause <= r_trap_cause;
            end
            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready)    r_state <= S_DECODE;
                    else if (w_tmo_hit) r_state <= S_TRAP;
                    else                r_state <= S_FETCH;
                end
                S_DECODE: begin
                    case (w_class)
                        CLS_R:              r_state <= S_EXEC_R;
                        CLS_LDUR, CLS_STUR: r_state <= S_ADDR;
                        CLS_CBZ:            r_state <= S_CBZ;
                        CLS_B:              r_state <= S_BR;
                        default:            r_state <= S_TRAP;
                    endcase
                end
                S_EXEC_R: r_state <= S_WB_R;
                S_ADDR: begin
                    if (w_class == CLS_STUR) r_state <= S_MEM_WR;
                    else                     r_state <= S_MEM_RD;
                end
                S_MEM_RD: begin
                    if (i_mem_ready)    r_state <= S_WB_LD;
                    else if (w_tmo_hit) r_state <= S_TRAP;
                    else                r_state <= S_MEM_RD;
                end
                S_MEM_WR: begin
                    if (i_mem_ready)    r_state <= S_FETCH;
                    else if (w_tmo_hit) r_state <= S_TRAP;
                    else                r_state <= S_MEM_WR;
                end
                S_WB_R, S_WB_LD, S_CBZ, S_BR: r_state <= S_FETCH;
                default: r_state <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl: per-cycle expected control vectors
// are queued as each step is driven and compared mid-cycle against the outputs.
module tb_legv8_multicycle_ctrl;

    typedef struct packed {
        logic       pc_we, pc_src, ir_we;
        logic [1:0] imm_sel, src_a, src_b, alu_op;
        logic       mem_req, mem_we, iord, reg_we, mem_to_reg, retire, trap;
        logic [1:0] cause;
    } ov_t;

    localparam int TMO = 16;
    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_SUB  = 32'hCB020020;
    localparam logic [31:0] I_AND  = 32'h8A020020;
    localparam logic [31:0] I_ORR  = 32'hAA020020;
    localparam logic [31:0] I_LDUR = 32'hF84083E1;
    localparam logic [31:0] I_STUR = 32'hF80083E1;
    localparam logic [31:0] I_CBZ  = 32'hB4000040;
    localparam logic [31:0] I_B    = 32'h14000003;
    localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero, mem_ready;
    logic        pc_we, pc_src, ir_we, mem_req, mem_we, iord, reg_we, mem_to_reg, retire, trap;
    logic [1:0]  imm_sel, alu_src_a, alu_src_b, alu_op, trap_cause;
    ov_t         obs;
    ov_t         sb_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    legv8_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .i_instr(instr), .i_alu_zero(alu_zero),
        .i_mem_ready(mem_ready), .o_pc_we(pc_we), .o_pc_src(pc_src), .o_ir_we(ir_we),
        .o_imm_sel(imm_sel), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_alu_op(alu_op), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord),
        .o_reg_we(reg_we), .o_mem_to_reg(mem_to_reg), .o_retire(retire),
        .o_trap(trap), .o_trap_cause(trap_cause)
    );

    assign obs = {pc_we, pc_src, ir_we, imm_sel, alu_src_a, alu_src_b, alu_op,
                  mem_req, mem_we, iord, reg_we, mem_to_reg, retire, trap, trap_cause};

    function automatic ov_t f_fetch(input logic rdy, input logic ret);
        ov_t v = '0;
        v.mem_req = 1'b1; v.src_b = 2'b01; v.ir_we = rdy; v.pc_we = rdy; v.retire = ret;
        return v;
    endfunction
    function automatic ov_t f_decode(input logic [1:0] imm);
        ov_t v = '0;
        v.src_a = 2'b01; v.src_b = 2'b11; v.imm_sel = imm;
        return v;
    endfunction
    function automatic ov_t f_exec_r();
        ov_t v = '0;
        v.src_a = 2'b10; v.alu_op = 2'b10;
        return v;
    endfunction
    function automatic ov_t f_wb(input logic from_mem);
        ov_t v = '0;
        v.reg_we = 1'b1; v.mem_to_reg = from_mem; v.retire = 1'b1;
        return v;
    endfunction
    function automatic ov_t f_addr();
        ov_t v = '0;
        v.src_a = 2'b10; v.src_b = 2'b10;
        return v;
    endfunction
    function automatic ov_t f_mem(input logic we);
        ov_t v = '0;
        v.mem_req = 1'b1; v.iord = 1'b1; v.mem_we = we;
        return v;
    endfunction
    function automatic ov_t f_cbz(input logic zero);
        ov_t v = '0;
        v.src_a = 2'b10; v.alu_op = 2'b01; v.pc_we = zero; v.pc_src = 1'b1; v.retire = 1'b1;
        return v;
    endfunction
    function automatic ov_t f_br();
        ov_t v = '0;
        v.pc_we = 1'b1; v.pc_src = 1'b1; v.retire = 1'b1;
        return v;
    endfunction
    function automatic ov_t f_trap(input logic [1:0] cause);
        ov_t v = '0;
        v.trap = 1'b1; v.cause = cause;
        return v;
    endfunction

    task automatic check(input string tag);
        ov_t ex;
        ex = sb_q.pop_front();
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, ex);
        end
    endtask

    // Drives one cycle's inputs at the falling edge and checks just after.
    task automatic step(input string tag, input logic rdy, input logic zero,
                        input logic [31:0] ins, input ov_t e);
        mem_ready = rdy; alu_zero = zero; instr = ins;
        sb_q.push_back(e);
        #1;
        check(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
        sb_q.push_back(ov_t'(0));
        #1;
        check(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_r(input string tag, input logic [31:0] ins, input logic ret0);
        step({tag, "_f"}, 1'b1, 1'b0, ins, f_fetch(1'b1, ret0));
        step({tag, "_d"}, 1'b1, 1'b0, ins, f_decode(2'b00));
        step({tag, "_x"}, 1'b1, 1'b0, ins, f_exec_r());
        step({tag, "_wb"}, 1'b1, 1'b0, ins, f_wb(1'b0));
    endtask

    initial begin
        instr = 32'h0;
        do_reset("reset");

        run_r("add", I_ADD, 1'b0);
        run_r("sub", I_SUB, 1'b0);
        run_r("and", I_AND, 1'b0);
        run_r("orr", I_ORR, 1'b0);

        step("ld_f", 1'b1, 1'b0, I_LDUR, f_fetch(1'b1, 1'b0));
        step("ld_d", 1'b1, 1'b0, I_LDUR, f_decode(2'b00));
        step("ld_a", 1'b1, 1'b0, I_LDUR, f_addr());
        for (int i = 0; i < 3; i++) step("ld_wait", 1'b0, 1'b0, I_LDUR, f_mem(1'b0));
        step("ld_m", 1'b1, 1'b0, I_LDUR, f_mem(1'b0));
        step("ld_wb", 1'b1, 1'b0, I_LDUR, f_wb(1'b1));

        step("st_f", 1'b1, 1'b0, I_STUR, f_fetch(1'b1, 1'b0));
        step("st_d", 1'b1, 1'b0, I_STUR, f_decode(2'b00));
        step("st_a", 1'b1, 1'b0, I_STUR, f_addr());
        step("st_m", 1'b1, 1'b0, I_STUR, f_mem(1'b1));

        step("cbz1_f", 1'b1, 1'b1, I_CBZ, f_fetch(1'b1, 1'b1));
        step("cbz1_d", 1'b1, 1'b1, I_CBZ, f_decode(2'b01));
        step("cbz1_x", 1'b1, 1'b1, I_CBZ, f_cbz(1'b1));
        step("cbz0_f", 1'b1, 1'b0, I_CBZ, f_fetch(1'b1, 1'b0));
        step("cbz0_d", 1'b1, 1'b0, I_CBZ, f_decode(2'b01));
        step("cbz0_x", 1'b1, 1'b0, I_CBZ, f_cbz(1'b0));

        step("b_f", 1'b1, 1'b0, I_B, f_fetch(1'b1, 1'b0));
        step("b_d", 1'b1, 1'b0, I_B, f_decode(2'b10));
        step("b_x", 1'b1, 1'b0, I_B, f_br());
        step("b_next", 1'b0, 1'b0, I_B, f_fetch(1'b0, 1'b0));

        // Abort a store that is stalled on memory.
        do_reset("rst_pre_wr");
        step("wr_f", 1'b1, 1'b0, I_STUR, f_fetch(1'b1, 1'b0));
        step("wr_d", 1'b1, 1'b0, I_STUR, f_decode(2'b00));
        step("wr_a", 1'b1, 1'b0, I_STUR, f_addr());
        step("wr_wait0", 1'b0, 1'b0, I_STUR, f_mem(1'b1));
        step("wr_wait1", 1'b0, 1'b0, I_STUR, f_mem(1'b1));
        do_reset("rst_mid_wr");
        step("wr_after_rst", 1'b1, 1'b0, I_ADD, f_fetch(1'b1, 1'b0));

        do_reset("rst_pre_ill");
        step("ill_f", 1'b1, 1'b0, I_ILL, f_fetch(1'b1, 1'b0));
        step("ill_d", 1'b1, 1'b0, I_ILL, f_decode(2'b00));
        for (int i = 0; i < TMO + 2; i++) step("ill_trap", 1'b0, 1'b0, I_ILL, f_trap(2'b01));

        do_reset("rst_pre_tmo");
        for (int i = 0; i < TMO; i++) step("tmo_wait", 1'b0, 1'b0, I_ADD, f_fetch(1'b0, 1'b0));
        for (int i = 0; i < 3; i++) step("tmo_trap", 1'b1, 1'b0, I_ADD, f_trap(2'b10));

        do_reset("rst_pre_lim");
        for (int i = 0; i < TMO - 1; i++) step("lim_wait", 1'b0, 1'b0, I_ADD, f_fetch(1'b0, 1'b0));
        run_r("lim", I_ADD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
